// File: rtl/id_stage_pipe_if.sv
// ID/EX pipeline bundle: decoded controls and operands handed from decode to EX.
// Ports (master = decode stage, slave = EX stage):
//   ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch, ex_status_en, ex_imm : controls
//   ex_alu_cmd[3:0], ex_dest/ex_src1/ex_src2[AW-1:0] : ALU command and register indices
//   ex_rn_val/ex_rm_val/ex_pc[DATA_W-1:0] : operand values and PC+4
//   ex_shift_op[11:0], ex_imm24[23:0] : raw immediate fields
interface id_stage_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 4
);
  logic              ex_valid;
  logic              ex_wb_en;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_status_en;
  logic              ex_imm;
  logic [3:0]        ex_alu_cmd;
  logic [AW-1:0]     ex_dest;
  logic [AW-1:0]     ex_src1;
  logic [AW-1:0]     ex_src2;
  logic [DATA_W-1:0] ex_rn_val;
  logic [DATA_W-1:0] ex_rm_val;
  logic [DATA_W-1:0] ex_pc;
  logic [11:0]       ex_shift_op;
  logic [23:0]       ex_imm24;

  modport master (
    output ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch, ex_status_en, ex_imm,
           ex_alu_cmd, ex_dest, ex_src1, ex_src2, ex_rn_val, ex_rm_val, ex_pc,
           ex_shift_op, ex_imm24
  );

  modport slave (
    input ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_branch, ex_status_en, ex_imm,
          ex_alu_cmd, ex_dest, ex_src1, ex_src2, ex_rn_val, ex_rm_val, ex_pc,
          ex_shift_op, ex_imm24
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage with integrated ID/EX register: decodes the instruction, checks its
// condition against {N,Z,C,V}, reads the register file (write-through), detects RAW
// hazards against EX/MEM and loads EX, inserting a bubble on kill.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   pc_in, instr, in_valid    : instruction from IF/ID
//   flush                     : branch taken in EX, kill current decode
//   status                    : flags {N,Z,C,V}
//   wb_en, wb_dest, wb_data   : register-file write port
//   mem_wb_en, mem_dest       : destination of the instruction in MEM
//   stall                     : combinational, freezes PC and IF/ID
//   ex                        : registered ID/EX bundle
module id_stage_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_COUNT  = 16,
  parameter bit          FORWARD_EN = 1'b1,
  localparam int unsigned AW        = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instr,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [3:0]        status,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mem_wb_en,
  input  logic [AW-1:0]     mem_dest,
  output logic              stall,
  id_stage_pipe_if.master   ex
);

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              status_en;
    logic              imm;
    logic [3:0]        alu_cmd;
    logic [AW-1:0]     dest;
    logic [AW-1:0]     src1;
    logic [AW-1:0]     src2;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] rm_val;
    logic [DATA_W-1:0] pc;
    logic [11:0]       shift_op;
    logic [23:0]       imm24;
  } ex_t;

  ex_t ex_q, ex_d;

  logic [DATA_W-1:0] rf_q [REG_COUNT];

  // Instruction fields
  logic [3:0]    cond;
  logic [1:0]    mode;
  logic          i_bit;
  logic [3:0]    opcode;
  logic          s_bit;
  logic [AW-1:0] rn_a;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] rm_a;
  logic [AW-1:0] src2_a;

  assign cond   = instr[31:28];
  assign mode   = instr[27:26];
  assign i_bit  = instr[25];
  assign opcode = instr[24:21];
  assign s_bit  = instr[20];
  assign rn_a   = AW'(instr[19:16]);
  assign rd_a   = AW'(instr[15:12]);
  assign rm_a   = AW'(instr[3:0]);
  // Stores read the data register through the second port.
  assign src2_a = (mode == 2'b01 && !s_bit) ? rd_a : rm_a;

  // Control decode
  logic [3:0] alu_cmd;
  logic       dec_wb, dec_mr, dec_mw, dec_br, dec_st, use1, use2;

  always_comb begin
    alu_cmd = 4'b0000;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 1'b0;
    dec_st  = 1'b0;
    use1    = 1'b0;
    use2    = 1'b0;
    case (mode)
      2'b00: begin
        use1   = 1'b1;
        use2   = ~i_bit;
        dec_wb = 1'b1;
        dec_st = s_bit;
        case (opcode)
          4'b1101: begin alu_cmd = 4'b0001; use1 = 1'b0; end
          4'b1111: begin alu_cmd = 4'b1001; use1 = 1'b0; end
          4'b0100: alu_cmd = 4'b0010;
          4'b0101: alu_cmd = 4'b0011;
          4'b0010: alu_cmd = 4'b0100;
          4'b0110: alu_cmd = 4'b0101;
          4'b0000: alu_cmd = 4'b0110;
          4'b1100: alu_cmd = 4'b0111;
          4'b0001: alu_cmd = 4'b1000;
          4'b1010: begin alu_cmd = 4'b0100; dec_wb = 1'b0; dec_st = 1'b1; end
          4'b1000: begin alu_cmd = 4'b0110; dec_wb = 1'b0; dec_st = 1'b1; end
          default: begin
            use1   = 1'b0;
            use2   = 1'b0;
            dec_wb = 1'b0;
            dec_st = 1'b0;
          end
        endcase
      end
      2'b01: begin
        alu_cmd = 4'b0010;
        use1    = 1'b1;
        use2    = ~s_bit;
        dec_mr  = s_bit;
        dec_wb  = s_bit;
        dec_mw  = ~s_bit;
      end
      2'b10:   dec_br = 1'b1;
      default: ;
    endcase
  end

  // Condition evaluation against {N,Z,C,V}
  logic f_n, f_z, f_c, f_v, cond_pass;
  assign {f_n, f_z, f_c, f_v} = status;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = f_z;
      4'h1: cond_pass = ~f_z;
      4'h2: cond_pass = f_c;
      4'h3: cond_pass = ~f_c;
      4'h4: cond_pass = f_n;
      4'h5: cond_pass = ~f_n;
      4'h6: cond_pass = f_v;
      4'h7: cond_pass = ~f_v;
      4'h8: cond_pass = f_c & ~f_z;
      4'h9: cond_pass = ~f_c | f_z;
      4'hA: cond_pass = (f_n == f_v);
      4'hB: cond_pass = (f_n != f_v);
      4'hC: cond_pass = ~f_z & (f_n == f_v);
      4'hD: cond_pass = f_z | (f_n != f_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Register file reads with same-cycle write-through
  logic [DATA_W-1:0] rn_val, rm_val;
  always_comb begin
    rn_val = (wb_en && wb_dest == rn_a)   ? wb_data : rf_q[rn_a];
    rm_val = (wb_en && wb_dest == src2_a) ? wb_data : rf_q[src2_a];
  end

  // RAW hazard: with forwarding only a load in EX can block its consumer
  logic hz1, hz2, haz, kill;
  always_comb begin
    if (FORWARD_EN) begin
      hz1 = ex_q.valid & ex_q.mem_read & (ex_q.dest == rn_a);
      hz2 = ex_q.valid & ex_q.mem_read & (ex_q.dest == src2_a);
    end else begin
      hz1 = (ex_q.valid & ex_q.wb_en & (ex_q.dest == rn_a)) |
            (mem_wb_en & (mem_dest == rn_a));
      hz2 = (ex_q.valid & ex_q.wb_en & (ex_q.dest == src2_a)) |
            (mem_wb_en & (mem_dest == src2_a));
    end
    haz  = in_valid & ((use1 & hz1) | (use2 & hz2));
    kill = ~in_valid | ~cond_pass | haz | flush;
  end

  // Flush wins over hazard: the decode is discarded, so nothing to hold.
  assign stall = haz & ~flush;

  // Next ID/EX contents; kill forces a bubble on the control fields
  always_comb begin
    ex_d           = '0;
    ex_d.valid     = ~kill;
    ex_d.wb_en     = dec_wb & ~kill;
    ex_d.mem_read  = dec_mr & ~kill;
    ex_d.mem_write = dec_mw & ~kill;
    ex_d.branch    = dec_br & ~kill;
    ex_d.status_en = dec_st & ~kill;
    ex_d.alu_cmd   = kill ? 4'b0000 : alu_cmd;
    ex_d.imm       = i_bit;
    ex_d.dest      = rd_a;
    ex_d.src1      = use1 ? rn_a : '0;
    ex_d.src2      = use2 ? src2_a : '0;
    ex_d.rn_val    = rn_val;
    ex_d.rm_val    = rm_val;
    ex_d.pc        = pc_in;
    ex_d.shift_op  = instr[11:0];
    ex_d.imm24     = instr[23:0];
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[wb_dest] <= wb_data;
    end
  end

  assign ex.ex_valid     = ex_q.valid;
  assign ex.ex_wb_en     = ex_q.wb_en;
  assign ex.ex_mem_read  = ex_q.mem_read;
  assign ex.ex_mem_write = ex_q.mem_write;
  assign ex.ex_branch    = ex_q.branch;
  assign ex.ex_status_en = ex_q.status_en;
  assign ex.ex_imm       = ex_q.imm;
  assign ex.ex_alu_cmd   = ex_q.alu_cmd;
  assign ex.ex_dest      = ex_q.dest;
  assign ex.ex_src1      = ex_q.src1;
  assign ex.ex_src2      = ex_q.src2;
  assign ex.ex_rn_val    = ex_q.rn_val;
  assign ex.ex_rm_val    = ex_q.rm_val;
  assign ex.ex_pc        = ex_q.pc;
  assign ex.ex_shift_op  = ex_q.shift_op;
  assign ex.ex_imm24     = ex_q.imm24;

endmodule
